// File: rtl/display_pkg.sv
// Shared constants and types for the text display writer.
package display_pkg;
  localparam int DISP_COLS = 80;
  localparam int DISP_ROWS = 32;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} disp_wr_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction
endpackage

// File: rtl/display_text_writer_if.sv
// Producer byte handshake plus display memory write port.
interface display_text_writer_if #(parameter int ADDR_W = 12);
  logic [7:0]        char_data;
  logic              char_valid;
  logic              char_ready;
  logic              clr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;

  modport slave  (input  char_data, char_valid, clr_req,
                  output char_ready, wr_addr, wr_data, wr_en);
  modport master (output char_data, char_valid, clr_req,
                  input  char_ready, wr_addr, wr_data, wr_en);
endinterface

// File: rtl/display_text_writer.sv
// Cursor-tracking character writer for the 80x32 text buffer; handles LF/CR/BS
// and fills lines or the whole screen with spaces using one shared counter.
module display_text_writer
  import display_pkg::*;
#(
  parameter int COLS   = DISP_COLS,
  parameter int ROWS   = DISP_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  display_text_writer_if.slave bus,
  output logic [6:0]           cur_x,
  output logic [4:0]           cur_y,
  output logic                 busy
);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_FILL = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  disp_wr_state_t    state_q, state_d;
  logic [6:0]        cur_x_q, cur_x_d;
  logic [4:0]        cur_y_q, cur_y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              row_adv;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
      fill_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
      fill_q     <= fill_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    fill_d     = fill_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    row_adv    = 1'b0;
    // A clear request wins over everything, including a pending byte.
    if (bus.clr_req) begin
      state_d = CLR_ALL;
      fill_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.char_valid) begin
          if (is_printable(bus.char_data)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base_q + ADDR_W'(cur_x_q);
            wr_data_d = bus.char_data;
            if (cur_x_q == LAST_COL) row_adv = 1'b1;
            else                     cur_x_d = cur_x_q + 7'd1;
          end else if (bus.char_data == ASCII_LF) begin
            row_adv = 1'b1;
          end else if (bus.char_data == ASCII_CR) begin
            cur_x_d = '0;
          end else if (bus.char_data == ASCII_BS && cur_x_q != '0) begin
            cur_x_d   = cur_x_q - 7'd1;
            wr_en_d   = 1'b1;
            wr_addr_d = row_base_q + ADDR_W'(cur_x_q - 7'd1);
            wr_data_d = ASCII_SPACE;
          end
          if (row_adv) begin
            cur_x_d = '0;
            state_d = CLR_LINE;
            fill_d  = '0;
            if (cur_y_q == LAST_ROW) begin
              cur_y_d    = '0;
              row_base_d = '0;
            end else begin
              cur_y_d    = cur_y_q + 5'd1;
              row_base_d = row_base_q + ROW_STEP;
            end
          end
        end
        CLR_LINE: begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_base_q + fill_q;
          wr_data_d = ASCII_SPACE;
          if (fill_q == LAST_FILL) state_d = IDLE;
          else                     fill_d  = fill_q + 1'b1;
        end
        CLR_ALL: begin
          wr_en_d   = 1'b1;
          wr_addr_d = fill_q;
          wr_data_d = ASCII_SPACE;
          if (fill_q == LAST_CELL) begin
            state_d    = IDLE;
            cur_x_d    = '0;
            cur_y_d    = '0;
            row_base_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q != IDLE);
    bus.char_ready = (state_q == IDLE) && !bus.clr_req;
    bus.wr_en      = wr_en_q;
    bus.wr_addr    = wr_addr_q;
    bus.wr_data    = wr_data_q;
    cur_x          = cur_x_q;
    cur_y          = cur_y_q;
  end
endmodule

// File: tb/tb_display_text_writer.sv
// Scoreboard bench for display_text_writer: expected writes are queued as
// stimulus is issued, a negedge monitor pops and compares each wr_en pulse.
module tb_display_text_writer;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;
  int         total = 0;
  int         bad = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  logic        mon_en = 1'b1;

  always #5 clk = ~clk;

  display_text_writer_if #(.ADDR_W(12)) bus();

  display_text_writer #(.COLS(80), .ROWS(32), .ADDR_W(12)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always @(negedge clk) begin
    if (resetn && mon_en && bus.wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== mon_e) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.wr_addr, bus.wr_data, mon_e[19:8], mon_e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    exp_q.push_back({12'(a), d});
  endtask

  task automatic push_row(input int base);
    for (int i = 0; i < 80; i++) push(base + i, 8'h20);
  endtask

  // Present a byte and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.char_data  = b;
    bus.char_valid = 1'b1;
    n = 0;
    while (!bus.char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1 bus.char_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_not_busy", busy, 0);
  endtask

  initial begin
    int  n;
    logic ok_ready;
    bus.char_data  = 8'h00;
    bus.char_valid = 1'b0;
    bus.clr_req    = 1'b0;
    #12;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_x", cur_x, 0);
    chk("rst_cur_y", cur_y, 0);
    chk("rst_ready", bus.char_ready, 1);
    @(negedge clk);
    resetn = 1'b1;

    // 'H','i' at the top-left corner
    push(0, 8'h48);
    send(8'h48);
    chk("wr_en_after_accept", bus.wr_en, 1);
    push(1, 8'h69);
    send(8'h69);
    drain();
    chk("hi_cur_x", cur_x, 2);
    chk("hi_cur_y", cur_y, 0);

    // walk down to row 3, type 5 chars, then LF from (5,3)
    for (int r = 1; r <= 3; r++) begin
      push_row(80 * r);
      send(8'h0A);
    end
    for (int i = 0; i < 5; i++) begin
      push(240 + i, 8'(8'h61 + i));
      send(8'(8'h61 + i));
    end
    drain();
    chk("pre_lf_cur_x", cur_x, 5);
    chk("pre_lf_cur_y", cur_y, 3);
    push_row(320);
    send(8'h0A);
    chk("lf_busy", busy, 1);
    chk("lf_ready_low", bus.char_ready, 0);
    chk("lf_cur_x", cur_x, 0);
    chk("lf_cur_y", cur_y, 4);
    repeat (40) @(negedge clk);
    chk("lf_mid_ready_low", bus.char_ready, 0);
    drain();
    chk("lf_ready_back", bus.char_ready, 1);

    // down to row 31, fill it, wrap clears row 0
    for (int r = 5; r <= 31; r++) begin
      push_row(80 * r);
      send(8'h0A);
    end
    for (int i = 0; i < 80; i++) begin
      push(2480 + i, 8'(8'h41 + (i % 26)));
      if (i == 79) push_row(0);
      send(8'(8'h41 + (i % 26)));
    end
    drain();
    chk("wrap_cur_x", cur_x, 0);
    chk("wrap_cur_y", cur_y, 0);

    // BS at column 0, an unknown control byte, then BS at (10,1)
    send(8'h08);
    send(8'h01);
    drain();
    chk("bs0_cur_x", cur_x, 0);
    chk("bs0_cur_y", cur_y, 0);
    push_row(80);
    send(8'h0A);
    for (int i = 0; i < 10; i++) begin
      push(80 + i, 8'(8'h30 + i));
      send(8'(8'h30 + i));
    end
    drain();
    chk("pre_bs_cur_x", cur_x, 10);
    push(89, 8'h20);
    send(8'h08);
    drain();
    chk("bs_cur_x", cur_x, 9);
    chk("bs_cur_y", cur_y, 1);
    send(8'h0D);
    drain();
    chk("cr_cur_x", cur_x, 0);
    chk("cr_cur_y", cur_y, 1);

    // clr_req three writes into a line clear, with a byte held pending
    push(160, 8'h20); push(161, 8'h20); push(162, 8'h20);
    for (int a = 0; a < 2560; a++) push(a, 8'h20);
    send(8'h0A);
    @(negedge clk);
    bus.char_data  = 8'h5A;
    bus.char_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    ok_ready = 1'b1;
    n = 0;
    while (busy && n < 6000) begin
      if (bus.char_ready) ok_ready = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("clr_ready_low", ok_ready, 1);
    chk("clr_done_busy", busy, 0);
    chk("clr_done_cur_x", cur_x, 0);
    chk("clr_done_cur_y", cur_y, 0);
    push(0, 8'h5A);
    @(posedge clk);
    #1 bus.char_valid = 1'b0;
    drain();
    chk("after_clr_cur_x", cur_x, 1);

    // async reset in the middle of a full clear
    mon_en = 1'b0;
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    repeat (100) @(negedge clk);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_wr_en", bus.wr_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cur_x", cur_x, 0);
    chk("arst_cur_y", cur_y, 0);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;
    chk("arst_ready", bus.char_ready, 1);
    push(0, 8'h51);
    send(8'h51);
    drain();
    chk("arst_after_cur_x", cur_x, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
